// File: rtl/duty_cycle_monitor.sv
// Measures period and high time of a sampled divided clock in clockin cycles.
// Define DUTY_MON_SYNC_EN to add a two-flop synchronizer when sig_in is asynchronous.
module duty_cycle_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clockin,
  input  logic             reset,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             duty_half,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {ARM, MEAS} state_t;

  state_t           r_state, w_state_next;
  logic             r_s, r_s_prev;
  logic             w_s_in, w_rise;
  logic [CNT_W-1:0] r_period_acc, w_period_acc_next;
  logic [CNT_W-1:0] r_high_acc, w_high_acc_next;
  logic [CNT_W-1:0] r_period_cnt, w_period_cnt_next;
  logic [CNT_W-1:0] r_high_cnt, w_high_cnt_next;
  logic             r_meas_valid, w_meas_valid_next;
  logic             r_duty_half, w_duty_half_next;
  logic             r_ovf, w_ovf_next;

`ifdef DUTY_MON_SYNC_EN
  logic r_sync1, r_sync2;

  always_ff @(posedge clockin) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s_in = r_sync2;
`else
  assign w_s_in = sig_in;
`endif

  assign w_rise = r_s & ~r_s_prev;

  always_comb begin
    w_state_next      = r_state;
    w_period_acc_next = r_period_acc;
    w_high_acc_next   = r_high_acc;
    w_period_cnt_next = r_period_cnt;
    w_high_cnt_next   = r_high_cnt;
    w_meas_valid_next = 1'b0;
    w_duty_half_next  = r_duty_half;
    w_ovf_next        = r_ovf;
    if (!en) begin
      w_state_next      = ARM;
      w_period_acc_next = '0;
      w_high_acc_next   = '0;
    end else begin
      case (r_state)
        ARM: begin
          w_period_acc_next = '0;
          w_high_acc_next   = '0;
          if (w_rise) begin
            w_state_next      = MEAS;
            w_period_acc_next = CNT_ONE;
            w_high_acc_next   = CNT_ONE;
          end
        end
        MEAS: begin
          // A rise on the max-count cycle still publishes; overflow only without it.
          if (w_rise) begin
            w_period_cnt_next = r_period_acc;
            w_high_cnt_next   = r_high_acc;
            w_duty_half_next  = ({r_high_acc, 1'b0} == {1'b0, r_period_acc});
            w_meas_valid_next = 1'b1;
            w_period_acc_next = CNT_ONE;
            w_high_acc_next   = CNT_ONE;
          end else if (r_period_acc == CNT_MAX) begin
            w_ovf_next        = 1'b1;
            w_state_next      = ARM;
            w_period_acc_next = '0;
            w_high_acc_next   = '0;
          end else begin
            w_period_acc_next = r_period_acc + CNT_ONE;
            w_high_acc_next   = r_high_acc + {{(CNT_W-1){1'b0}}, r_s};
          end
        end
        default: w_state_next = ARM;
      endcase
    end
  end

  always_ff @(posedge clockin) begin
    if (reset) begin
      r_state      <= ARM;
      r_s          <= 1'b0;
      r_s_prev     <= 1'b0;
      r_period_acc <= '0;
      r_high_acc   <= '0;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_meas_valid <= 1'b0;
      r_duty_half  <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_s          <= w_s_in;
      r_s_prev     <= r_s;
      r_period_acc <= w_period_acc_next;
      r_high_acc   <= w_high_acc_next;
      r_period_cnt <= w_period_cnt_next;
      r_high_cnt   <= w_high_cnt_next;
      r_meas_valid <= w_meas_valid_next;
      r_duty_half  <= w_duty_half_next;
      r_ovf        <= w_ovf_next;
    end
  end

  assign high_cnt   = r_high_cnt;
  assign period_cnt = r_period_cnt;
  assign meas_valid = r_meas_valid;
  assign duty_half  = r_duty_half;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_duty_cycle_monitor.sv
// Scoreboard bench for duty_cycle_monitor: an 8-bit and a 4-bit instance driven with directed sig_in patterns.
module tb_duty_cycle_monitor;

`ifdef DUTY_MON_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int p;
    int h;
    bit d;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en8 = 1'b0, en4 = 1'b0;
  logic       sig8 = 1'b0, sig4 = 1'b0;
  logic [7:0] hc8, pc8;
  logic [3:0] hc4, pc4;
  logic       mv8, dh8, ovf8, mv4, dh4, ovf4;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   prev8 = 1'b0, prev4 = 1'b0;
  exp_t q8[$];
  exp_t q4[$];

  duty_cycle_monitor #(.CNT_W(8)) dut8 (
    .clockin(clk), .reset(reset), .en(en8), .sig_in(sig8),
    .high_cnt(hc8), .period_cnt(pc8), .meas_valid(mv8), .duty_half(dh8), .ovf(ovf8)
  );

  duty_cycle_monitor #(.CNT_W(4)) dut4 (
    .clockin(clk), .reset(reset), .en(en4), .sig_in(sig4),
    .high_cnt(hc4), .period_cnt(pc4), .meas_valid(mv4), .duty_half(dh4), .ovf(ovf4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", nm, act, req);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  // Drive one sig_in sample; a publishing rise predicts its meas_valid cycle.
  task automatic step(input int sel, input bit v, input bit pub,
                      input int ep, input int eh, input bit ed);
    exp_t e;
    @(posedge clk);
    #1;
    e.p = ep; e.h = eh; e.d = ed; e.cyc = cyc + 2 + LAT;
    if (sel == 0) begin
      if (v && !prev8 && pub) q8.push_back(e);
      sig8 = v; prev8 = v;
    end else begin
      if (v && !prev4 && pub) q4.push_back(e);
      sig4 = v; prev4 = v;
    end
  endtask

  task automatic run_pattern(input int sel, input logic [31:0] pat, input int len, input int reps,
                             input bit skip, input int ep, input int eh, input bit ed);
    bit armed = skip;
    bit v, pv, rise;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < len; i++) begin
        v    = pat[len-1-i];
        pv   = (sel == 0) ? prev8 : prev4;
        rise = v && !pv;
        step(sel, v, rise && !armed, ep, eh, ed);
        if (rise) armed = 1'b0;
      end
    end
  endtask

  initial begin : mon8
    exp_t e;
    forever begin
      @(negedge clk);
      if (mv8) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL pub8_unexpected cyc=%0d got p=%0d h=%0d required no meas_valid", cyc, pc8, hc8);
        end else begin
          e = q8.pop_front();
          if (int'(pc8) != e.p || int'(hc8) != e.h || dh8 != e.d || cyc != e.cyc) begin
            errors++;
            $display("FAIL pub8 got p=%0d h=%0d d=%0d cyc=%0d required p=%0d h=%0d d=%0d cyc=%0d",
                     pc8, hc8, dh8, cyc, e.p, e.h, e.d, e.cyc);
          end else begin
            $display("pub8 p=%0d h=%0d d=%0d cyc=%0d", pc8, hc8, dh8, cyc);
          end
        end
      end
    end
  end

  initial begin : mon4
    exp_t e;
    forever begin
      @(negedge clk);
      if (mv4) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL pub4_unexpected cyc=%0d got p=%0d h=%0d required no meas_valid", cyc, pc4, hc4);
        end else begin
          e = q4.pop_front();
          if (int'(pc4) != e.p || int'(hc4) != e.h || dh4 != e.d || cyc != e.cyc) begin
            errors++;
            $display("FAIL pub4 got p=%0d h=%0d d=%0d cyc=%0d required p=%0d h=%0d d=%0d cyc=%0d",
                     pc4, hc4, dh4, cyc, e.p, e.h, e.d, e.cyc);
          end else begin
            $display("pub4 p=%0d h=%0d d=%0d cyc=%0d", pc4, hc4, dh4, cyc);
          end
        end
      end
    end
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_high_cnt", hc8, 0);
    chk("rst_period_cnt", pc8, 0);
    chk("rst_meas_valid", mv8, 0);
    chk("rst_duty_half", dh8, 0);
    chk("rst_ovf", ovf8, 0);
    @(posedge clk);
    #1 reset = 1'b0; en8 = 1'b1;

    // Mod-5 bit-1 waveform: period 5, high 2
    run_pattern(0, 32'b00110, 5, 6, 1'b1, 5, 2, 1'b0);
    @(negedge clk);
    chk("mod5_ovf", ovf8, 0);

    // Rearm, then 50 % waveform: period 4, high 2
    en8 = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    en8 = 1'b1;
    run_pattern(0, 32'b1100, 4, 5, 1'b1, 4, 2, 1'b1);

    // Drop en mid-period; interrupted period must not publish
    step(0, 1, 1, 4, 2, 1'b1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    en8 = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    en8 = 1'b1;
    run_pattern(0, 32'b1100, 4, 3, 1'b1, 4, 2, 1'b1);
    @(negedge clk);
    chk("en_q8_drained", q8.size(), 0);

    // One-cycle reset in the middle of a period
    step(0, 1, 1, 4, 2, 1'b1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_high_cnt", hc8, 0);
    chk("midrst_period_cnt", pc8, 0);
    chk("midrst_meas_valid", mv8, 0);
    chk("midrst_duty_half", dh8, 0);
    chk("midrst_ovf", ovf8, 0);
    run_pattern(0, 32'b1100, 4, 3, 1'b1, 4, 2, 1'b1);
    @(negedge clk);
    chk("rst_q8_drained", q8.size(), 0);
    en8 = 1'b0;

    // CNT_W=4: period of exactly 15 publishes at the counter maximum
    en4 = 1'b1;
    run_pattern(1, 32'b111000000000000, 15, 3, 1'b1, 15, 3, 1'b0);
    @(negedge clk);
    chk("max_ovf", ovf4, 0);
    en4 = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    en4 = 1'b1;

    // CNT_W=4: one rise then constant high -> overflow 15 cycles after MEAS entry
    step(1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step(1, 1, 0, 0, 0, 0);
      if (k == 16 + LAT || k == 17 + LAT) begin
        @(negedge clk);
        chk($sformatf("ovf_at_k%0d", k), ovf4, (k == 17 + LAT) ? 1 : 0);
      end
    end
    chk("ovf_hold_period", pc4, 15);
    chk("ovf_hold_high", hc4, 3);
    run_pattern(1, 32'b1100, 4, 3, 1'b1, 4, 2, 1'b1);
    @(negedge clk);
    chk("ovf_sticky", ovf4, 1);

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("q8_empty", q8.size(), 0);
    chk("q4_empty", q4.size(), 0);

    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("final_rst_ovf", ovf4, 0);
    chk("final_rst_period", pc4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
